// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the core control logic and the PC sequencer.
// master = core side driving requests; slave = sequencer driving fetch state.
interface pc_sequencer_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 stall;
    logic                 redirect_valid;
    logic [WIDTH-1:0]     redirect_target;
    logic                 trap_req;
    logic                 mret_req;
    logic                 halt_req;
    logic                 resume_req;
    logic [WIDTH-1:0]     pc;
    logic [WIDTH-1:0]     pc_plus4;
    logic [WIDTH-1:0]     epc;
    logic                 fetch_valid;
    logic                 halted;
    logic                 misaligned;
    logic [CNT_WIDTH-1:0] instret;

    modport master (
        output stall, redirect_valid, redirect_target, trap_req, mret_req,
               halt_req, resume_req,
        input  pc, pc_plus4, epc, fetch_valid, halted, misaligned, instret
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, trap_req, mret_req,
               halt_req, resume_req,
        output pc, pc_plus4, epc, fetch_valid, halted, misaligned, instret
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, trap/mret, debug halt, instret.
// Optional macro PC_ALIGN_CHECK_EN turns misaligned redirects into traps.
module pc_sequencer #(
    parameter int unsigned         WIDTH        = 32,
    parameter logic [WIDTH-1:0]    RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]    TRAP_VECTOR  = WIDTH'(32'h0000_0100),
    parameter int unsigned         CNT_WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst,
    pc_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     pc_q, pc_d;
    logic [WIDTH-1:0]     epc_q, epc_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;
    logic [WIDTH-1:0]     pc_plus4;
    logic                 misalign_trap;

    assign pc_plus4 = pc_q + WIDTH'(4);

`ifdef PC_ALIGN_CHECK_EN
    // Only a redirect that actually wins the priority can become a misalign trap.
    assign misalign_trap = (state_q == RUN) && bus.redirect_valid
                           && !bus.trap_req && !bus.mret_req
                           && (bus.redirect_target[1:0] != 2'b00);
`else
    assign misalign_trap = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        instret_d = instret_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (bus.trap_req) begin
                    pc_d  = TRAP_VECTOR;
                    epc_d = pc_q;
                end else if (bus.mret_req) begin
                    pc_d = epc_q;
                end else if (bus.redirect_valid) begin
                    if (misalign_trap) begin
                        pc_d  = TRAP_VECTOR;
                        epc_d = pc_q;
                    end else begin
                        pc_d = bus.redirect_target & ~WIDTH'(3);
                    end
                end else if (!bus.stall) begin
                    pc_d = pc_plus4;
                end
                if (!bus.stall && !bus.trap_req && !misalign_trap)
                    instret_d = instret_q + CNT_WIDTH'(1);
                if (bus.halt_req)
                    state_d = HALT;
            end
            HALT: begin
                if (bus.resume_req)
                    state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VECTOR;
            epc_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            instret_q <= instret_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.epc         = epc_q;
    assign bus.fetch_valid = (state_q == RUN);
    assign bus.halted      = (state_q == HALT);
    assign bus.misaligned  = misalign_trap;
    assign bus.instret     = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer: 32-bit instance driven from a table,
// 8-bit instance with a 4-bit counter exercised by hand for wrap-around.
module tb_pc_sequencer;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst32;
    logic rst8;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.WIDTH(32), .CNT_WIDTH(32)) b32 ();
    pc_sequencer_if #(.WIDTH(8),  .CNT_WIDTH(4))  b8 ();

    pc_sequencer #(
        .WIDTH(32), .RESET_VECTOR(32'h80), .TRAP_VECTOR(32'h100), .CNT_WIDTH(32)
    ) dut32 (
        .clk(clk), .rst(rst32), .bus(b32)
    );

    pc_sequencer #(
        .WIDTH(8), .RESET_VECTOR(8'hF8), .TRAP_VECTOR(8'h10), .CNT_WIDTH(4)
    ) dut8 (
        .clk(clk), .rst(rst8), .bus(b8)
    );

    typedef struct {
        logic        rst, stall, rv;
        logic [31:0] tgt;
        logic        trap, mret, halt, resume;
        logic [31:0] pc, epc;
        logic        fv, hl;
        logic [31:0] ir;
        logic        mis;
    } vec_t;

    localparam int NV = 31;
    vec_t vt[NV];

    function automatic vec_t mk(logic r, logic st, logic rv, logic [31:0] tg,
                                logic tr, logic mr, logic hr, logic rs,
                                logic [31:0] pc, logic [31:0] epc, logic fv,
                                logic hl, logic [31:0] ir, logic mis);
        vec_t v;
        v.rst = r; v.stall = st; v.rv = rv; v.tgt = tg;
        v.trap = tr; v.mret = mr; v.halt = hr; v.resume = rs;
        v.pc = pc; v.epc = epc; v.fv = fv; v.hl = hl; v.ir = ir; v.mis = mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] ep_al;
        ep_al = ALIGN ? 32'h50 : 32'h20;
        //               rst st rv tgt        tr mr hr rs   pc       epc      fv hl ir  mis
        vt[0]  = mk(1, 0, 0, 32'h0,   0, 0, 0, 0,  32'h80,  32'h0,   0, 0, 0,  0);
        vt[1]  = mk(0, 0, 1, 32'h44,  1, 0, 0, 0,  32'h80,  32'h0,   1, 0, 0,  0);
        vt[2]  = mk(0, 0, 0, 32'h0,   0, 0, 0, 0,  32'h84,  32'h0,   1, 0, 1,  0);
        vt[3]  = mk(0, 0, 0, 32'h0,   0, 0, 0, 0,  32'h88,  32'h0,   1, 0, 2,  0);
        vt[4]  = mk(0, 0, 0, 32'h0,   0, 0, 0, 0,  32'h8C,  32'h0,   1, 0, 3,  0);
        vt[5]  = mk(0, 0, 1, 32'h10,  0, 0, 0, 0,  32'h10,  32'h0,   1, 0, 4,  0);
        vt[6]  = mk(0, 1, 0, 32'h0,   0, 0, 0, 0,  32'h10,  32'h0,   1, 0, 4,  0);
        vt[7]  = mk(0, 1, 0, 32'h0,   0, 0, 0, 0,  32'h10,  32'h0,   1, 0, 4,  0);
        vt[8]  = mk(0, 1, 0, 32'h0,   0, 0, 0, 0,  32'h10,  32'h0,   1, 0, 4,  0);
        vt[9]  = mk(0, 1, 1, 32'h40,  0, 0, 0, 0,  32'h40,  32'h0,   1, 0, 4,  0);
        vt[10] = mk(0, 0, 1, 32'h20,  0, 0, 0, 0,  32'h20,  32'h0,   1, 0, 5,  0);
        vt[11] = mk(0, 0, 1, 32'h44,  1, 1, 0, 0,  32'h100, 32'h20,  1, 0, 5,  0);
        vt[12] = mk(0, 0, 0, 32'h0,   0, 1, 0, 0,  32'h20,  32'h20,  1, 0, 6,  0);
        vt[13] = mk(0, 0, 1, 32'h30,  0, 0, 0, 0,  32'h30,  32'h20,  1, 0, 7,  0);
        vt[14] = mk(0, 0, 0, 32'h0,   0, 0, 1, 0,  32'h34,  32'h20,  0, 1, 8,  0);
        vt[15] = mk(0, 0, 0, 32'h0,   0, 0, 0, 0,  32'h34,  32'h20,  0, 1, 8,  0);
        vt[16] = mk(0, 1, 1, 32'h45,  1, 1, 0, 0,  32'h34,  32'h20,  0, 1, 8,  0);
        vt[17] = mk(0, 0, 0, 32'h0,   0, 0, 1, 0,  32'h34,  32'h20,  0, 1, 8,  0);
        vt[18] = mk(0, 0, 0, 32'h0,   0, 0, 0, 0,  32'h34,  32'h20,  0, 1, 8,  0);
        vt[19] = mk(0, 0, 0, 32'h0,   0, 0, 0, 0,  32'h34,  32'h20,  0, 1, 8,  0);
        vt[20] = mk(0, 0, 0, 32'h0,   0, 0, 1, 1,  32'h34,  32'h20,  1, 0, 8,  0);
        vt[21] = mk(0, 0, 0, 32'h0,   0, 0, 0, 0,  32'h38,  32'h20,  1, 0, 9,  0);
        vt[22] = mk(0, 0, 1, 32'h50,  0, 0, 0, 0,  32'h50,  32'h20,  1, 0, 10, 0);
        vt[23] = mk(0, 0, 1, 32'h42,  0, 0, 0, 0,  ALIGN ? 32'h100 : 32'h40,
                    ep_al, 1, 0, ALIGN ? 32'd10 : 32'd11, ALIGN);
        vt[24] = mk(0, 0, 1, 32'h43,  0, 1, 0, 0,  ep_al,   ep_al,   1, 0,
                    ALIGN ? 32'd11 : 32'd12, 0);
        vt[25] = mk(0, 1, 0, 32'h0,   1, 0, 0, 0,  32'h100, ep_al,   1, 0,
                    ALIGN ? 32'd11 : 32'd12, 0);
        vt[26] = mk(1, 0, 0, 32'h0,   0, 0, 1, 0,  32'h80,  32'h0,   0, 0, 0,  0);
        vt[27] = mk(0, 0, 0, 32'h0,   0, 0, 0, 0,  32'h80,  32'h0,   1, 0, 0,  0);
        vt[28] = mk(0, 0, 0, 32'h0,   0, 0, 1, 0,  32'h84,  32'h0,   0, 1, 1,  0);
        vt[29] = mk(1, 0, 0, 32'h0,   0, 0, 0, 1,  32'h80,  32'h0,   0, 0, 0,  0);
        vt[30] = mk(0, 0, 0, 32'h0,   0, 0, 0, 0,  32'h80,  32'h0,   1, 0, 0,  0);

        rst32 = 1'b1; rst8 = 1'b1;
        b32.stall = 0; b32.redirect_valid = 0; b32.redirect_target = '0;
        b32.trap_req = 0; b32.mret_req = 0; b32.halt_req = 0; b32.resume_req = 0;
        b8.stall = 0; b8.redirect_valid = 0; b8.redirect_target = '0;
        b8.trap_req = 0; b8.mret_req = 0; b8.halt_req = 0; b8.resume_req = 0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst32 = vt[i].rst;
            b32.stall = vt[i].stall; b32.redirect_valid = vt[i].rv;
            b32.redirect_target = vt[i].tgt; b32.trap_req = vt[i].trap;
            b32.mret_req = vt[i].mret; b32.halt_req = vt[i].halt;
            b32.resume_req = vt[i].resume;
            #1;
            chk($sformatf("v%0d misaligned", i), {31'b0, b32.misaligned}, {31'b0, vt[i].mis});
            if (i > 0)
                chk($sformatf("v%0d pc_plus4", i), b32.pc_plus4, vt[i-1].pc + 32'd4);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pc", i), b32.pc, vt[i].pc);
            chk($sformatf("v%0d epc", i), b32.epc, vt[i].epc);
            chk($sformatf("v%0d fetch_valid", i), {31'b0, b32.fetch_valid}, {31'b0, vt[i].fv});
            chk($sformatf("v%0d halted", i), {31'b0, b32.halted}, {31'b0, vt[i].hl});
            chk($sformatf("v%0d instret", i), b32.instret, vt[i].ir);
        end

        // 8-bit instance: pc wrap at 0xFC and 4-bit instret wrap.
        @(negedge clk);
        rst8 = 1'b0;
        @(posedge clk); #1;
        chk("w8 boot pc", {24'b0, b8.pc}, 32'hF8);
        chk("w8 boot fv", {31'b0, b8.fetch_valid}, 32'd1);
        chk("w8 pc_plus4 at F8", {24'b0, b8.pc_plus4}, 32'hFC);
        @(posedge clk); #1;
        chk("w8 pc FC", {24'b0, b8.pc}, 32'hFC);
        chk("w8 pc_plus4 wrap", {24'b0, b8.pc_plus4}, 32'h00);
        @(posedge clk); #1;
        chk("w8 pc wrap", {24'b0, b8.pc}, 32'h00);
        chk("w8 instret 2", {28'b0, b8.instret}, 32'd2);
        repeat (14) @(posedge clk);
        #1;
        chk("w8 pc after 14", {24'b0, b8.pc}, 32'h38);
        chk("w8 instret wrap", {28'b0, b8.instret}, 32'd0);
        chk("w8 misaligned", {31'b0, b8.misaligned}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
